dbus_arb_interconnect: RTL and testbench
========================================

Name: dbus_arb_interconnect

Overview:
- Parametrised next-generation data-bus interconnect: NUM_MASTERS master ports to NUM_SLAVES slave ports.
- Adds round-robin arbitration, registered request/response paths, programmable address-tag decode, decode-miss error and slave-timeout error.
- Sits between core/debug masters and memory/peripheral slaves; one transaction in flight at a time.

Parameters:
NUM_MASTERS, 2, number of master ports (1..8)
NUM_SLAVES, 3, number of slave ports (1..16)
DATA_W, 32, data width
ADDR_W, 32, address width
TAG_MSB, 31, upper bit of decode field
TAG_LSB, 28, lower bit of decode field
SLAVE_TAGS, {4'h2,4'h1,4'hF}, packed NUM_SLAVES x (TAG_MSB-TAG_LSB+1) tag values; slot i = slave i
TIMEOUT, 255, max cycles waiting for slave bdone (8-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_breq  in  NUM_MASTERS  bus request per master
m_bgnt  out  NUM_MASTERS  grant, one-hot or zero
m_bstart  in  NUM_MASTERS  transaction start strobe
m_addr  in  NUM_MASTERS*ADDR_W  address
m_wdata  in  NUM_MASTERS*DATA_W  write data
m_tsize  in  NUM_MASTERS*2  transfer size
m_ttype  in  NUM_MASTERS  0=read 1=write
m_rdata  out  DATA_W  read data (shared, qualified by bdone+bgnt)
m_bdone  out  NUM_MASTERS  completion pulse to owner
m_berror  out  NUM_MASTERS  error flag, valid with bdone
s_ss  out  NUM_SLAVES  slave select, one-hot or zero
s_bstart  out  1  start strobe to slaves
s_addr  out  ADDR_W  broadcast address
s_wdata  out  DATA_W  broadcast write data
s_tsize  out  2  broadcast size
s_ttype  out  1  broadcast type
s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data
s_bdone  in  NUM_SLAVES  per-slave completion
s_berror  in  NUM_SLAVES  per-slave error, valid with s_bdone

Behaviour:
- Reset (rst_n low, any time incl. mid-transaction): all outputs 0, state IDLE, rr pointer 0, timeout counter 0. Transaction in flight is abandoned.
- States: IDLE, GRANT, ACTIVE, RESP.
- IDLE: any m_breq -> winner = first requester at or after rr pointer (wrapping); m_bgnt[winner] registered high next cycle; -> GRANT.
- GRANT: owner m_breq low -> drop bgnt, -> IDLE. Owner m_bstart high at cycle T: latch addr/wdata/tsize/ttype; decode addr[TAG_MSB:TAG_LSB] against SLAVE_TAGS (lowest index wins on duplicate tags).
  - Hit slave k: cycle T+1 s_ss[k]=1, s_bstart=1 (one cycle), s_addr/wdata/tsize/ttype = latched values; -> ACTIVE.
  - Miss: cycle T+1 m_bdone[owner]=1, m_berror[owner]=1, m_rdata=0, no s_ss; -> RESP.
  - m_bstart from non-owners ignored.
- ACTIVE: s_ss[k] and slave-side data held stable. s_bdone[k] at cycle U -> cycle U+1 m_bdone[owner]=1, m_rdata=s_rdata[k] (registered), m_berror=s_berror[k], s_ss cleared; -> RESP. s_bdone from unselected slaves ignored.
  - Timeout counter increments each ACTIVE cycle; reaching TIMEOUT without s_bdone -> next cycle m_bdone=1, m_berror=1, m_rdata=0, s_ss cleared; -> RESP. Late s_bdone afterwards ignored.
- RESP (the bdone cycle): m_bgnt cleared next cycle; rr pointer = owner+1 mod NUM_MASTERS; -> IDLE. New grant earliest 2 cycles after bdone; owner must re-request.
- m_bdone/m_berror are single-cycle pulses; m_rdata holds last value until next bdone.
- Owner dropping breq in ACTIVE does not abort; transaction completes, bgnt released at RESP.
- NUM_MASTERS=1: arbitration degenerates; pointer stays 0.

Test Plan:
- Single read: M0 breq, bstart addr 0xF000_0010 -> s_ss=3'b001 one cycle after bstart; slave0 bdone with rdata 0xDEADBEEF -> m_bdone[0]=1, m_rdata=0xDEADBEEF next cycle, berror=0.
- Round-robin: M0,M1 breq held continuously, each doing reads to 0x1000_0000 -> grant order M0,M1,M0,M1; s_ss=3'b010 each time.
- Decode miss: M1 bstart addr 0x7000_0000 -> next cycle m_bdone[1]=1, m_berror[1]=1, s_ss=0, s_bstart never asserted.
- Timeout: slave2 never responds to 0x2000_0004 write -> m_bdone=1, m_berror=1 after TIMEOUT cycles in ACTIVE; later s_bdone[2] produces no m_bdone.
- Slave error: slave0 returns s_bdone with s_berror=1 -> m_berror[owner]=1 with bdone.
- Reset mid-ACTIVE: rst_n low while s_ss[0]=1 -> all outputs 0 immediately; after release, M1 request granted first (pointer 0 ignored since M0 idle).

Source files
------------

// File: rtl/dbus_arb_interconnect.sv
// Data-bus interconnect: round-robin arbitration of NUM_MASTERS masters onto
// NUM_SLAVES tag-decoded slaves, one transaction in flight, decode-miss and timeout errors.
//   state  | meaning
//   IDLE   | no owner, arbitrating pending requests
//   GRANT  | owner granted, waiting for its bstart (or breq drop)
//   ACTIVE | slave selected, waiting for its bdone or timeout
//   RESP   | bdone cycle to owner; release grant, advance pointer
module dbus_arb_interconnect #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TAG_MSB     = 31,
  parameter int TAG_LSB     = 28,
  parameter logic [NUM_SLAVES*(TAG_MSB-TAG_LSB+1)-1:0] SLAVE_TAGS = {4'h2, 4'h1, 4'hF},
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_breq,
  output logic [NUM_MASTERS-1:0]        m_bgnt,
  input  logic [NUM_MASTERS-1:0]        m_bstart,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]      m_tsize,
  input  logic [NUM_MASTERS-1:0]        m_ttype,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_bdone,
  output logic [NUM_MASTERS-1:0]        m_berror,
  output logic [NUM_SLAVES-1:0]         s_ss,
  output logic                          s_bstart,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [1:0]                    s_tsize,
  output logic                          s_ttype,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]         s_bdone,
  input  logic [NUM_SLAVES-1:0]         s_berror
);
  localparam int TW  = TAG_MSB - TAG_LSB + 1;
  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, RESP} state_t;

  state_t           state;
  logic [MIW-1:0]   rr_ptr, owner;
  logic [SIW-1:0]   sel;
  logic [7:0]       to_cnt;

  logic             arb_found;
  logic [MIW-1:0]   arb_idx;
  logic             own_breq, own_bstart, own_ttype;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [1:0]       own_tsize;
  logic [TW-1:0]    own_tag;
  logic             dec_hit;
  logic [SIW-1:0]   dec_idx;
  logic             sl_bdone, sl_berror;
  logic [DATA_W-1:0] sl_rdata;
  logic [NUM_MASTERS-1:0] owner_oh;

  // Round robin: first pass looks at or after the pointer, second pass wraps.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!arb_found && m_breq[i] && (MIW'(i) >= rr_ptr)) begin
        arb_found = 1'b1;
        arb_idx   = MIW'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!arb_found && m_breq[i]) begin
        arb_found = 1'b1;
        arb_idx   = MIW'(i);
      end
    end
  end

  always_comb begin
    own_breq   = 1'b0;
    own_bstart = 1'b0;
    own_addr   = '0;
    own_wdata  = '0;
    own_tsize  = '0;
    own_ttype  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == MIW'(i)) begin
        own_breq   = m_breq[i];
        own_bstart = m_bstart[i];
        own_addr   = m_addr[i*ADDR_W +: ADDR_W];
        own_wdata  = m_wdata[i*DATA_W +: DATA_W];
        own_tsize  = m_tsize[i*2 +: 2];
        own_ttype  = m_ttype[i];
      end
    end
  end

  assign own_tag  = own_addr[TAG_MSB:TAG_LSB];
  assign owner_oh = NUM_MASTERS'(1) << owner;

  // Descending scan so the lowest matching slot wins on duplicate tags.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (own_tag == SLAVE_TAGS[i*TW +: TW]) begin
        dec_hit = 1'b1;
        dec_idx = SIW'(i);
      end
    end
  end

  always_comb begin
    sl_bdone  = 1'b0;
    sl_berror = 1'b0;
    sl_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SIW'(i)) begin
        sl_bdone  = s_bdone[i];
        sl_berror = s_berror[i];
        sl_rdata  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      sel      <= '0;
      to_cnt   <= '0;
      m_bgnt   <= '0;
      m_bdone  <= '0;
      m_berror <= '0;
      m_rdata  <= '0;
      s_ss     <= '0;
      s_bstart <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_tsize  <= '0;
      s_ttype  <= 1'b0;
    end else begin
      m_bdone  <= '0;
      m_berror <= '0;
      s_bstart <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            owner  <= arb_idx;
            m_bgnt <= NUM_MASTERS'(1) << arb_idx;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (!own_breq) begin
            m_bgnt <= '0;
            state  <= IDLE;
          end else if (own_bstart) begin
            if (dec_hit) begin
              sel      <= dec_idx;
              s_ss     <= NUM_SLAVES'(1) << dec_idx;
              s_bstart <= 1'b1;
              s_addr   <= own_addr;
              s_wdata  <= own_wdata;
              s_tsize  <= own_tsize;
              s_ttype  <= own_ttype;
              to_cnt   <= '0;
              state    <= ACTIVE;
            end else begin
              m_bdone  <= owner_oh;
              m_berror <= owner_oh;
              m_rdata  <= '0;
              state    <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (sl_bdone) begin
            m_bdone  <= owner_oh;
            m_berror <= sl_berror ? owner_oh : '0;
            m_rdata  <= sl_rdata;
            s_ss     <= '0;
            state    <= RESP;
          end else if (to_cnt == 8'(TIMEOUT - 1)) begin
            m_bdone  <= owner_oh;
            m_berror <= owner_oh;
            m_rdata  <= '0;
            s_ss     <= '0;
            state    <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        RESP: begin
          m_bgnt <= '0;
          rr_ptr <= (owner == MIW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
          to_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_arb_interconnect.sv
// Scoreboard bench for dbus_arb_interconnect: expected completions are queued as
// responses are driven and checked by a monitor when m_bdone fires.
module tb_dbus_arb_interconnect;
  localparam int NM = 2;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] m_breq, m_bgnt, m_bstart, m_ttype, m_bdone, m_berror;
  logic [NM*32-1:0] m_addr, m_wdata;
  logic [NM*2-1:0]  m_tsize;
  logic [31:0]   m_rdata;
  logic [NS-1:0] s_ss, s_bdone, s_berror;
  logic          s_bstart, s_ttype;
  logic [31:0]   s_addr, s_wdata;
  logic [1:0]    s_tsize;
  logic [NS*32-1:0] s_rdata;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  dbus_arb_interconnect dut (
    .clk(clk), .rst_n(rst_n),
    .m_breq(m_breq), .m_bgnt(m_bgnt), .m_bstart(m_bstart), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_tsize(m_tsize), .m_ttype(m_ttype), .m_rdata(m_rdata),
    .m_bdone(m_bdone), .m_berror(m_berror),
    .s_ss(s_ss), .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_tsize(s_tsize), .s_ttype(s_ttype), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .s_berror(s_berror)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every bdone must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && m_bdone !== '0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_bdone: got m_bdone=%b m_berror=%b, expected none", m_bdone, m_berror);
      end else begin
        exp_t e;
        logic [NM-1:0] oh;
        e  = sb.pop_front();
        oh = NM'(1) << e.m;
        if (m_bdone !== oh || m_berror !== (e.err ? oh : '0) || m_rdata !== e.rdata) begin
          n_err++;
          $display("FAIL completion: got bdone=%b berror=%b rdata=%h, expected bdone=%b berror=%b rdata=%h",
                   m_bdone, m_berror, m_rdata, oh, e.err ? oh : '0, e.rdata);
        end
      end
    end
  end

  task automatic push_exp(input int m, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.m = m; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic start_txn(input int m, input logic [31:0] addr, input logic tt,
                           input logic [31:0] wd, input logic [1:0] sz);
    m_addr[m*32 +: 32] = addr;
    m_wdata[m*32 +: 32] = wd;
    m_tsize[m*2 +: 2]  = sz;
    m_ttype[m]         = tt;
    m_bstart[m]        = 1'b1;
    tick();
    m_bstart[m]        = 1'b0;
  endtask

  task automatic slave_resp(input int k, input logic [31:0] rd, input logic err);
    s_rdata[k*32 +: 32] = rd;
    s_berror[k]         = err;
    s_bdone[k]          = 1'b1;
    tick();
    s_bdone  = '0;
    s_berror = '0;
  endtask

  task automatic wait_gnt(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_bgnt[m] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m_bgnt, m_bdone, m_berror, m_rdata, s_ss, s_bstart, s_addr, s_wdata, s_tsize, s_ttype} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got bgnt=%b ss=%b bstart=%b addr=%h, expected all zero",
               m_bgnt, s_ss, s_bstart, s_addr);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    m_breq[0] = 1'b1;
    wait_gnt(0, ok);
    n_cmp++;
    if (!ok || m_bgnt !== 2'b01) begin
      n_err++; $display("FAIL read_grant: got bgnt=%b, expected 01", m_bgnt);
    end
    start_txn(0, 32'hF000_0010, 1'b0, 32'h0, 2'b10);
    n_cmp++;
    if (s_ss !== 3'b001 || s_bstart !== 1'b1 || s_addr !== 32'hF000_0010 || s_ttype !== 1'b0) begin
      n_err++;
      $display("FAIL read_select: got ss=%b bstart=%b addr=%h ttype=%b, expected 001 1 f0000010 0",
               s_ss, s_bstart, s_addr, s_ttype);
    end
    tick();
    n_cmp++;
    if (s_bstart !== 1'b0 || s_ss !== 3'b001) begin
      n_err++; $display("FAIL bstart_pulse: got bstart=%b ss=%b, expected 0 001", s_bstart, s_ss);
    end
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    slave_resp(0, 32'hDEAD_BEEF, 1'b0);
    n_cmp++;
    if (m_bdone !== 2'b01 || m_rdata !== 32'hDEAD_BEEF || s_ss !== 3'b000) begin
      n_err++;
      $display("FAIL read_done: got bdone=%b rdata=%h ss=%b, expected 01 deadbeef 000", m_bdone, m_rdata, s_ss);
    end
    m_breq = '0;
    tick();
    n_cmp++;
    if (m_bgnt !== 2'b00 || m_bdone !== 2'b00 || m_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_release: got bgnt=%b bdone=%b rdata=%h, expected 00 00 deadbeef", m_bgnt, m_bdone, m_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [NM-1:0] exp_g;
    do_reset();
    m_breq = 2'b11;
    for (int t = 0; t < 4; t++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (m_bgnt !== '0) begin ok = 1'b1; break; end
        tick();
      end
      exp_g = NM'(1) << (t % 2);
      n_cmp++;
      if (!ok || m_bgnt !== exp_g) begin
        n_err++; $display("FAIL rr_order[%0d]: got bgnt=%b, expected %b", t, m_bgnt, exp_g);
        break;
      end
      start_txn(t % 2, 32'h1000_0000, 1'b0, 32'h0, 2'b00);
      n_cmp++;
      if (s_ss !== 3'b010) begin
        n_err++; $display("FAIL rr_select[%0d]: got ss=%b, expected 010", t, s_ss);
      end
      push_exp(t % 2, 32'hA000_0000 + t, 1'b0);
      slave_resp(1, 32'hA000_0000 + t, 1'b0);
      tick();
      n_cmp++;
      if (m_bgnt !== '0) begin
        n_err++; $display("FAIL rr_gap[%0d]: got bgnt=%b one cycle after bdone, expected 00", t, m_bgnt);
      end
    end
    m_breq = '0;
    tick();
    tick();
  endtask

  task automatic test_decode_miss();
    bit ok;
    m_breq[1] = 1'b1;
    wait_gnt(1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL miss_grant: got bgnt=%b, expected 10", m_bgnt); end
    push_exp(1, 32'h0, 1'b1);
    start_txn(1, 32'h7000_0000, 1'b0, 32'h0, 2'b00);
    n_cmp++;
    if (m_bdone !== 2'b10 || m_berror !== 2'b10 || s_ss !== 3'b000 || s_bstart !== 1'b0) begin
      n_err++;
      $display("FAIL miss_resp: got bdone=%b berror=%b ss=%b bstart=%b, expected 10 10 000 0",
               m_bdone, m_berror, s_ss, s_bstart);
    end
    m_breq = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    m_breq[0] = 1'b1;
    wait_gnt(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL to_grant: got bgnt=%b, expected 01", m_bgnt); end
    start_txn(0, 32'h2000_0004, 1'b1, 32'h1234_5678, 2'b10);
    n_cmp++;
    if (s_ss !== 3'b100 || s_ttype !== 1'b1 || s_wdata !== 32'h1234_5678 || s_tsize !== 2'b10) begin
      n_err++;
      $display("FAIL to_select: got ss=%b ttype=%b wdata=%h tsize=%b, expected 100 1 12345678 10",
               s_ss, s_ttype, s_wdata, s_tsize);
    end
    push_exp(0, 32'h0, 1'b1);
    n = 0;
    while (m_bdone === '0 && n < 400) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 255 || s_ss !== 3'b000) begin
      n_err++; $display("FAIL timeout_latency: got %0d cycles ss=%b, expected 255 cycles ss=000", n, s_ss);
    end
    tick();
    s_bdone[2] = 1'b1;
    tick();
    s_bdone = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (m_bdone !== '0) begin
        n_err++; $display("FAIL late_bdone: got m_bdone=%b, expected 00", m_bdone);
      end
      tick();
    end
    m_breq = '0;
    tick();
    tick();
  endtask

  task automatic test_slave_error();
    bit ok;
    m_breq[1] = 1'b1;
    wait_gnt(1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL err_grant: got bgnt=%b, expected 10", m_bgnt); end
    start_txn(1, 32'hF000_0100, 1'b0, 32'h0, 2'b01);
    slave_resp(1, 32'h5555_5555, 1'b0);
    n_cmp++;
    if (m_bdone !== '0 || s_ss !== 3'b001) begin
      n_err++; $display("FAIL unselected_bdone: got bdone=%b ss=%b, expected 00 001", m_bdone, s_ss);
    end
    push_exp(1, 32'hCAFE_0001, 1'b1);
    slave_resp(0, 32'hCAFE_0001, 1'b1);
    n_cmp++;
    if (m_bdone !== 2'b10 || m_berror !== 2'b10) begin
      n_err++; $display("FAIL slave_error: got bdone=%b berror=%b, expected 10 10", m_bdone, m_berror);
    end
    m_breq = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_active();
    bit ok;
    m_breq[0] = 1'b1;
    wait_gnt(0, ok);
    start_txn(0, 32'hF000_0020, 1'b0, 32'h0, 2'b00);
    n_cmp++;
    if (!ok || s_ss !== 3'b001) begin
      n_err++; $display("FAIL mid_setup: got ss=%b, expected 001", s_ss);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_bgnt, m_bdone, m_berror, m_rdata, s_ss, s_bstart, s_addr, s_wdata, s_tsize, s_ttype} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got bgnt=%b ss=%b addr=%h, expected all zero", m_bgnt, s_ss, s_addr);
    end
    m_breq = 2'b10;
    tick();
    rst_n = 1'b1;
    wait_gnt(1, ok);
    n_cmp++;
    if (!ok || m_bgnt !== 2'b10) begin
      n_err++; $display("FAIL post_reset_grant: got bgnt=%b, expected 10", m_bgnt);
    end
    push_exp(1, 32'h0, 1'b1);
    start_txn(1, 32'h7000_0000, 1'b0, 32'h0, 2'b00);
    m_breq = '0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    m_breq = '0; m_bstart = '0; m_addr = '0; m_wdata = '0; m_tsize = '0; m_ttype = '0;
    s_rdata = '0; s_bdone = '0; s_berror = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_decode_miss();
    test_timeout();
    test_slave_error();
    test_reset_mid_active();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending completions, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
